// File: rtl/mandelbrot_scan_engine_if.sv
// Host-side control, serial configuration and pixel stream of the Mandelbrot scan engine.
// The host (pin mux / RP2040 side) uses the master modport; the engine uses the slave modport.
interface mandelbrot_scan_engine_if #(
  parameter int CTRWIDTH = 7,
  parameter int XBITS    = 4,
  parameter int YBITS    = 4
);
  logic                cfg_shift_en;
  logic                cfg_data;
  logic                cfg_commit;
  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic                pix_valid;
  logic                pix_ready;
  logic [XBITS-1:0]    pix_x;
  logic [YBITS-1:0]    pix_y;
  logic [CTRWIDTH-1:0] pix_count;
  logic                pix_escaped;

  modport master (
    output cfg_shift_en, cfg_data, cfg_commit, start, abort, pix_ready,
    input  busy, done, pix_valid, pix_x, pix_y, pix_count, pix_escaped
  );

  modport slave (
    input  cfg_shift_en, cfg_data, cfg_commit, start, abort, pix_ready,
    output busy, done, pix_valid, pix_x, pix_y, pix_count, pix_escaped
  );
endinterface

// File: rtl/mandelbrot_scan_engine.sv
// Raster-scan Mandelbrot engine: one iteration per cycle, results on a valid/ready stream.
// Configuration arrives serially and is latched per frame so a scan never sees it change.
module mandelbrot_scan_engine #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int XBITS    = 4,
  parameter int YBITS    = 4
) (
  input logic clk,
  input logic reset,
  mandelbrot_scan_engine_if.slave bus
);

  localparam int FRAC    = BITWIDTH - 3;
  localparam int CFG_LEN = CTRWIDTH + 2 + 2 * BITWIDTH;
  localparam int PW      = 2 * BITWIDTH + 2;
  localparam logic signed [PW-1:0] ESC_LIMIT = PW'(4) << (2 * FRAC);

  typedef enum logic [1:0] {IDLE, INIT, ITER, OUT} state_t;

  state_t                     r_state;
  logic [CFG_LEN-1:0]         r_shift;
  logic [CFG_LEN-1:0]         r_active;
  logic [CFG_LEN-1:0]         r_frame;
  logic [XBITS-1:0]           r_x;
  logic [YBITS-1:0]           r_y;
  logic signed [BITWIDTH-1:0] r_zr;
  logic signed [BITWIDTH-1:0] r_zi;
  logic signed [BITWIDTH-1:0] r_cr;
  logic signed [BITWIDTH-1:0] r_ci;
  logic [CTRWIDTH-1:0]        r_ctr;
  logic                       r_ovf;
  logic [CTRWIDTH-1:0]        r_count;
  logic                       r_escaped;
  logic                       r_pixValid;
  logic                       r_busy;
  logic                       r_done;

  logic [CTRWIDTH-1:0]        w_maxCtr;
  logic [1:0]                 w_scaling;
  logic [BITWIDTH-1:0]        w_ciOff;
  logic [BITWIDTH-1:0]        w_crOff;
  logic [BITWIDTH-1:0]        w_xOff;
  logic [BITWIDTH-1:0]        w_yOff;
  logic signed [PW-1:0]       w_zrExt;
  logic signed [PW-1:0]       w_ziExt;
  logic signed [PW-1:0]       w_crExt;
  logic signed [PW-1:0]       w_ciExt;
  logic signed [PW-1:0]       w_zrSq;
  logic signed [PW-1:0]       w_ziSq;
  logic signed [PW-1:0]       w_zrZi;
  logic signed [PW-1:0]       w_mag;
  logic signed [PW-1:0]       w_zrNext;
  logic signed [PW-1:0]       w_ziNext;
  logic                       w_zrOvf;
  logic                       w_ziOvf;
  logic                       w_escape;
  logic                       w_xfer;
  logic                       w_lastPixel;

  // Field layout of a config word: {max_ctr, scaling, ci_off, cr_off}, cr_off in the LSBs.
  assign w_maxCtr  = r_frame[CFG_LEN-1 -: CTRWIDTH];
  assign w_scaling = r_frame[2*BITWIDTH +: 2];
  assign w_ciOff   = r_frame[BITWIDTH +: BITWIDTH];
  assign w_crOff   = r_frame[0 +: BITWIDTH];

  assign w_xOff = BITWIDTH'(r_x) << w_scaling;
  assign w_yOff = BITWIDTH'(r_y) << w_scaling;

  assign w_zrExt = {{(PW-BITWIDTH){r_zr[BITWIDTH-1]}}, r_zr};
  assign w_ziExt = {{(PW-BITWIDTH){r_zi[BITWIDTH-1]}}, r_zi};
  assign w_crExt = {{(PW-BITWIDTH){r_cr[BITWIDTH-1]}}, r_cr};
  assign w_ciExt = {{(PW-BITWIDTH){r_ci[BITWIDTH-1]}}, r_ci};

  // Products are kept at full precision; >>> floors, so truncation goes toward -inf.
  assign w_zrSq   = w_zrExt * w_zrExt;
  assign w_ziSq   = w_ziExt * w_ziExt;
  assign w_zrZi   = w_zrExt * w_ziExt;
  assign w_mag    = w_zrSq + w_ziSq;
  assign w_zrNext = ((w_zrSq - w_ziSq) >>> FRAC) + w_crExt;
  assign w_ziNext = ((w_zrZi <<< 1) >>> FRAC) + w_ciExt;

  // A value fits BITWIDTH bits only if every bit above the new sign bit matches it.
  assign w_zrOvf = !((&w_zrNext[PW-1:BITWIDTH-1]) || !(|w_zrNext[PW-1:BITWIDTH-1]));
  assign w_ziOvf = !((&w_ziNext[PW-1:BITWIDTH-1]) || !(|w_ziNext[PW-1:BITWIDTH-1]));

  assign w_escape    = r_ovf || (w_mag >= ESC_LIMIT);
  assign w_xfer      = r_pixValid && bus.pix_ready;
  assign w_lastPixel = (&r_x) && (&r_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (bus.cfg_shift_en) begin
      r_shift <= {r_shift[CFG_LEN-2:0], bus.cfg_data};
    end
  end

  // Start snapshots the active config before a same-cycle commit replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_active   <= '0;
      r_frame    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_zr       <= '0;
      r_zi       <= '0;
      r_cr       <= '0;
      r_ci       <= '0;
      r_ctr      <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_escaped  <= 1'b0;
      r_pixValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.abort) begin
      r_state    <= IDLE;
      r_pixValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cfg_commit) begin
            r_active <= r_shift;
          end
          if (bus.start) begin
            r_frame <= r_active;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_zr    <= '0;
          r_zi    <= '0;
          r_ctr   <= '0;
          r_ovf   <= 1'b0;
          r_cr    <= w_crOff + w_xOff;
          r_ci    <= w_ciOff + w_yOff;
          r_state <= ITER;
        end
        ITER: begin
          if (w_escape) begin
            r_count    <= r_ctr;
            r_escaped  <= 1'b1;
            r_pixValid <= 1'b1;
            r_state    <= OUT;
          end else if (r_ctr == w_maxCtr) begin
            r_count    <= r_ctr;
            r_escaped  <= 1'b0;
            r_pixValid <= 1'b1;
            r_state    <= OUT;
          end else begin
            r_zr  <= w_zrNext[BITWIDTH-1:0];
            r_zi  <= w_ziNext[BITWIDTH-1:0];
            r_ovf <= w_zrOvf || w_ziOvf;
            r_ctr <= r_ctr + 1'b1;
          end
        end
        OUT: begin
          if (w_xfer) begin
            r_pixValid <= 1'b0;
            if (w_lastPixel) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              if (&r_x) begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
              r_state <= INIT;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pix_valid   = r_pixValid;
  assign bus.pix_x       = r_x;
  assign bus.pix_y       = r_y;
  assign bus.pix_count   = r_count;
  assign bus.pix_escaped = r_escaped;

endmodule
